// File: rtl/keypad_scan_driver.sv
// Row-scanning 4x4 keypad decoder: synchronizes columns, scans rows, debounces press/release.
// Optional ASCII translation of the accepted code is compiled in with KEYPAD_ASCII_EN.
module keypad_scan_driver #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk_Teclado,
  input  logic       rst,
  input  logic [3:0] Columna,
  output logic [3:0] Fila,
  output logic [7:0] cod,
  output logic       key_valid,
  output logic       key_held,
  output logic [6:0] ascii
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE);
  localparam logic [3:0]    ROWS_ALL = 4'b1111;
  localparam logic [3:0]    ROW_TOP  = 4'b1000;
  localparam logic [3:0]    ROW_BOT  = 4'b0001;

  typedef enum logic [1:0] {IDLE, SCAN, CONFIRM, RELEASE} state_t;
  state_t state_q, state_d;

  logic [3:0]    sync1_q, sync1_d, col_s_q, col_s_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    fila_q, fila_d, col_l_q, col_l_d, row_l_q, row_l_d;
  logic [DW-1:0] dbc_q, dbc_d, dbc_inc;
  logic [7:0]    cod_q, cod_d;
  logic          key_valid_q, key_valid_d, key_held_q, key_held_d;
  logic          tick, one_hot, col_match, col_zero, db_done;

  assign tick      = (pre_q == PRE_LAST);
  assign one_hot   = (col_s_q != 4'b0000) && ((col_s_q & (col_s_q - 4'd1)) == 4'b0000);
  assign col_match = (col_s_q == col_l_q);
  assign col_zero  = (col_s_q == 4'b0000);
  assign dbc_inc   = dbc_q + DW'(1);
  assign db_done   = (dbc_inc == DB_MAX);

  // State register plus all datapath flops
  always_ff @(posedge clk_Teclado) begin
    if (rst) begin
      state_q     <= IDLE;
      sync1_q     <= 4'b0000;
      col_s_q     <= 4'b0000;
      pre_q       <= '0;
      fila_q      <= ROWS_ALL;
      col_l_q     <= 4'b0000;
      row_l_q     <= 4'b0000;
      dbc_q       <= '0;
      cod_q       <= 8'h00;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      col_s_q     <= col_s_d;
      pre_q       <= pre_d;
      fila_q      <= fila_d;
      col_l_q     <= col_l_d;
      row_l_q     <= row_l_d;
      dbc_q       <= dbc_d;
      cod_q       <= cod_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (tick) begin
      case (state_q)
        IDLE:    if (one_hot) state_d = SCAN;
        SCAN:    if (col_match) state_d = CONFIRM;
                 else if (fila_q == ROW_BOT) state_d = IDLE;
        CONFIRM: if (!col_match) state_d = IDLE;
                 else if (db_done) state_d = RELEASE;
        RELEASE: if (col_zero && db_done) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    sync1_d     = Columna;
    col_s_d     = sync1_q;
    pre_d       = tick ? '0 : pre_q + PW'(1);
    fila_d      = fila_q;
    col_l_d     = col_l_q;
    row_l_d     = row_l_q;
    dbc_d       = dbc_q;
    cod_d       = cod_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    case (state_q)
      IDLE: begin
        fila_d = ROWS_ALL;
        if (tick && one_hot) begin
          col_l_d = col_s_q;
          fila_d  = ROW_TOP;
        end
      end
      // colS seen on this tick reflects the row driven since the previous tick
      SCAN: if (tick) begin
        if (col_match) begin
          row_l_d = fila_q;
          fila_d  = ROWS_ALL;
          dbc_d   = '0;
        end else if (fila_q == ROW_BOT) begin
          fila_d = ROWS_ALL;
        end else begin
          fila_d = fila_q >> 1;
        end
      end
      CONFIRM: if (tick && col_match) begin
        if (db_done) begin
          cod_d       = {row_l_q, col_l_q};
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          dbc_d       = '0;
        end else begin
          dbc_d = dbc_inc;
        end
      end
      RELEASE: begin
        fila_d = ROWS_ALL;
        if (tick) begin
          if (!col_zero) begin
            dbc_d = '0;
          end else if (db_done) begin
            key_held_d = 1'b0;
            dbc_d      = '0;
          end else begin
            dbc_d = dbc_inc;
          end
        end
      end
      default: fila_d = ROWS_ALL;
    endcase
  end

  always_comb begin
    Fila      = fila_q;
    cod       = cod_q;
    key_valid = key_valid_q;
    key_held  = key_held_q;
  end

`ifdef KEYPAD_ASCII_EN
  logic [6:0] ascii_q, ascii_d;

  function automatic logic [6:0] ascii_map(input logic [7:0] c);
    case (c)
      8'h82:   ascii_map = 7'h30;
      8'h11:   ascii_map = 7'h31;
      8'h12:   ascii_map = 7'h32;
      8'h14:   ascii_map = 7'h33;
      8'h21:   ascii_map = 7'h34;
      8'h22:   ascii_map = 7'h35;
      8'h24:   ascii_map = 7'h36;
      8'h41:   ascii_map = 7'h37;
      8'h42:   ascii_map = 7'h38;
      8'h44:   ascii_map = 7'h39;
      8'h81:   ascii_map = 7'h7F;
      8'h84:   ascii_map = 7'h0D;
      default: ascii_map = 7'h00;
    endcase
  endfunction

  always_comb ascii_d = key_valid_d ? ascii_map(cod_d) : ascii_q;

  always_ff @(posedge clk_Teclado) begin
    if (rst) ascii_q <= 7'h00;
    else     ascii_q <= ascii_d;
  end

  assign ascii = ascii_q;
`else
  assign ascii = 7'h00;
`endif

endmodule
